fig_7_7: RTL and testbench

- 4-word x 4-bit RAM built as a two-dimensional decoded array of binary cells, following the classic textbook "4x4 RAM" figure.
- A 2-to-4 address decoder, gated by mem_en, selects one word row.
- rd_wr picks the operation: 0 writes wr_data into the selected row; 1 drives the selected row onto rd_data.
- Used as a small teaching/reference storage block. It is standalone with a single clock domain.

---
 rtl/fig_7_7_pkg.sv | 8 +
 rtl/fig_7_7_binary_cell.sv | 21 ++
 rtl/fig_7_7.sv | 45 ++++
 tb/tb_fig_7_7.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fig_7_7_pkg.sv
// Shared geometry and word type for the 4x4 decoded-cell RAM.
package fig_7_7_pkg;
   localparam int ADDR_W    = 2;
   localparam int DATA_W    = 4;
   localparam int NUM_WORDS = 4;

   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/fig_7_7_binary_cell.sv
// One storage bit of the RAM; its output is gated so an unselected or
// writing cell contributes 0 to the column OR.
module fig_7_7_binary_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic select,
   input  logic rd_wr,
   input  logic in,
   output logic out
);
   logic bit_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bit_reg <= 1'b0;
      else if (select && !rd_wr)
         bit_reg <= in;
   end

   assign out = select & rd_wr & bit_reg;
endmodule

// File: rtl/fig_7_7.sv
// 4-word x 4-bit RAM: enable-gated 2-to-4 row decoder driving a 4x4 array
// of binary cells, with each column's cell outputs OR-ed onto rd_data.
module fig_7_7
   import fig_7_7_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_en,
   input  logic              rd_wr,
   input  logic [ADDR_W-1:0] addr,
   input  word_t             wr_data,
   output word_t             rd_data
);
   logic [NUM_WORDS-1:0] row_sel;
   logic [DATA_W-1:0]    cell_out [NUM_WORDS];

   always_comb begin
      row_sel = '0;
      if (mem_en)
         row_sel[addr] = 1'b1;
   end

   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM_WORDS; gi++) begin : g_row
         for (gj = 0; gj < DATA_W; gj++) begin : g_col
            fig_7_7_binary_cell u_cell (
               .clk    (clk),
               .rst_n  (rst_n),
               .select (row_sel[gi]),
               .rd_wr  (rd_wr),
               .in     (wr_data[gj]),
               .out    (cell_out[gi][gj])
            );
         end
      end
   endgenerate

   // Unselected rows output 0, so a plain OR per column yields the selected word.
   always_comb begin
      rd_data = '0;
      for (int r = 0; r < NUM_WORDS; r++)
         rd_data = rd_data | cell_out[r];
   end
endmodule

// File: tb/tb_fig_7_7.sv
// Self-checking bench for fig_7_7: directed plan plus random traffic
// against an array-based reference memory.
module tb_fig_7_7;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_en;
   logic       rd_wr;
   logic [1:0] addr;
   logic [3:0] wr_data;
   logic [3:0] rd_data;

   int checks = 0;
   int errors = 0;
   logic [3:0] model [4];

   fig_7_7 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mem_en  (mem_en),
      .rd_wr   (rd_wr),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] expected_rd();
      if (!rst_n || !mem_en || !rd_wr) return 4'b0000;
      return model[addr];
   endfunction

   // Drive inputs away from the active edge, then settle.
   task automatic drive(input logic en, input logic rw, input logic [1:0] a, input logic [3:0] d);
      @(negedge clk);
      mem_en = en; rd_wr = rw; addr = a; wr_data = d;
      #1;
   endtask

   // Take one rising edge and apply the write rule to the model.
   task automatic step();
      @(posedge clk);
      if (rst_n && mem_en && !rd_wr) model[addr] = wr_data;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; mem_en = 1'b1; rd_wr = 1'b1; addr = 2'd0; wr_data = 4'hF;
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) model[i] = 4'b0000;
      checks++;
      if (rd_data !== 4'b0000) begin
         errors++;
         $display("FAIL reset_held: rd_data=%b expected=0000", rd_data);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         drive(1'b1, 1'b1, a[1:0], 4'hF);
         checks++;
         if (rd_data !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sweep addr=%0d: rd_data=%b expected=0000", a, rd_data);
         end
         $display("reset sweep addr=%0d rd_data=%b", a, rd_data);
      end
   endtask

   task automatic test_write_read_word0();
      drive(1'b1, 1'b0, 2'd0, 4'b0001);
      checks++;
      if (rd_data !== 4'b0000) begin
         errors++;
         $display("FAIL w0_write_cycle: rd_data=%b expected=0000", rd_data);
      end
      step();
      drive(1'b1, 1'b1, 2'd0, 4'b0000);
      checks++;
      if (rd_data !== 4'b0001) begin
         errors++;
         $display("FAIL w0_read: rd_data=%b expected=0001", rd_data);
      end
      mem_en = 1'b0; #1;
      checks++;
      if (rd_data !== 4'b0000) begin
         errors++;
         $display("FAIL w0_disabled: rd_data=%b expected=0000", rd_data);
      end
      $display("word0 write 0001, read back ok path done");
   endtask

   task automatic test_word1_and_addr_change();
      drive(1'b1, 1'b0, 2'd1, 4'b0110);
      step();
      drive(1'b1, 1'b1, 2'd1, 4'b0000);
      checks++;
      if (rd_data !== 4'b0110) begin
         errors++;
         $display("FAIL w1_read: rd_data=%b expected=0110", rd_data);
      end
      addr = 2'd0; #1;   // same cycle, no edge in between
      checks++;
      if (rd_data !== 4'b0001) begin
         errors++;
         $display("FAIL addr_change_read: rd_data=%b expected=0001", rd_data);
      end
      $display("word1 write 0110, comb addr change read=%b", rd_data);
   endtask

   task automatic test_fill();
      logic [3:0] exp_vals [4];
      exp_vals[0] = 4'b0001; exp_vals[1] = 4'b0110;
      exp_vals[2] = 4'b1110; exp_vals[3] = 4'b1111;
      drive(1'b1, 1'b0, 2'd2, 4'b1110); step();
      drive(1'b1, 1'b0, 2'd3, 4'b1111); step();
      for (int a = 0; a < 4; a++) begin
         drive(1'b1, 1'b1, a[1:0], 4'h0);
         checks++;
         if (rd_data !== exp_vals[a] || rd_data !== model[a]) begin
            errors++;
            $display("FAIL fill_sweep addr=%0d: rd_data=%b expected=%b", a, rd_data, exp_vals[a]);
         end
         $display("fill sweep addr=%0d rd_data=%b", a, rd_data);
      end
   endtask

   task automatic test_disabled_write();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 2'd2, 4'b0000);
         checks++;
         if (rd_data !== 4'b0000) begin
            errors++;
            $display("FAIL disabled_idle cyc=%0d: rd_data=%b expected=0000", k, rd_data);
         end
         step();
      end
      drive(1'b1, 1'b1, 2'd2, 4'b0000);
      checks++;
      if (rd_data !== 4'b1110) begin
         errors++;
         $display("FAIL disabled_write_ignored: rd_data=%b expected=1110", rd_data);
      end
      $display("disabled write ignored, addr2=%b", rd_data);
   endtask

   task automatic test_random();
      logic       en, rw;
      logic [1:0] a;
      logic [3:0] d;
      logic [3:0] exp_v;
      for (int n = 0; n < 200; n++) begin
         en = 1'($urandom_range(0, 3) != 0);
         rw = 1'($urandom_range(0, 1));
         a  = 2'($urandom_range(0, 3));
         d  = 4'($urandom_range(0, 15));
         drive(en, rw, a, d);
         exp_v = expected_rd();
         checks++;
         if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL random n=%0d en=%b rw=%b addr=%0d: rd_data=%b expected=%b",
                     n, en, rw, a, rd_data, exp_v);
         end
         $display("random n=%0d en=%b rw=%b addr=%0d wr=%b rd=%b", n, en, rw, a, d, rd_data);
         step();
      end
      // Final read-back of every word to expose any stray writes.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, i[1:0], 4'h0);
         checks++;
         if (rd_data !== model[i]) begin
            errors++;
            $display("FAIL random_readback addr=%0d: rd_data=%b expected=%b", i, rd_data, model[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, i[1:0], 4'b1111 ^ 4'(i)); step();
      end
      drive(1'b1, 1'b1, 2'd0, 4'h0);
      checks++;
      if (rd_data !== 4'b1111) begin
         errors++;
         $display("FAIL async_pre: rd_data=%b expected=1111", rd_data);
      end
      // Start a write, then pull reset between edges.
      mem_en = 1'b1; rd_wr = 1'b0; addr = 2'd1; wr_data = 4'b1010;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 4'b0000;
      rd_wr = 1'b1; addr = 2'd3;
      #1;
      checks++;
      if (rd_data !== 4'b0000) begin
         errors++;
         $display("FAIL async_immediate: rd_data=%b expected=0000", rd_data);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         drive(1'b1, 1'b1, a[1:0], 4'h0);
         checks++;
         if (rd_data !== 4'b0000) begin
            errors++;
            $display("FAIL async_post addr=%0d: rd_data=%b expected=0000", a, rd_data);
         end
         $display("post async reset addr=%0d rd_data=%b", a, rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_write_read_word0();
      test_word1_and_addr_change();
      test_fill();
      test_disabled_write();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
